// File: rtl/sram_add_pkg.sv
// Shared types and defaults for the SRAM lane-wise add sequencer.
// Holds the sequencer state encoding and the default lane width.
package sram_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int LANE_BITS_DEF = 8;

endpackage

// File: rtl/sram_add_lane.sv
// One unsigned lane adder; SRAM_ADD_SATURATE_EN selects saturation,
// otherwise the sum wraps modulo 2**LANE_BITS.
module sram_add_lane #(
    parameter int LANE_BITS = 8
) (
    input  logic [LANE_BITS-1:0] a_i,
    input  logic [LANE_BITS-1:0] b_i,
    output logic [LANE_BITS-1:0] s_o
);

`ifdef SRAM_ADD_SATURATE_EN
    logic [LANE_BITS:0] sum;

    assign sum = {1'b0, a_i} + {1'b0, b_i};
    assign s_o = sum[LANE_BITS] ? '1 : sum[LANE_BITS-1:0];
`else
    assign s_o = a_i + b_i;
`endif

endmodule

// File: rtl/sram_add_sequencer.sv
// Streams A+B lane-wise from two SRAMs into SRAM C (C[i] = A[i] + B[i]).
// Optional saturating lanes via SRAM_ADD_SATURATE_EN.
module sram_add_sequencer
    import sram_add_pkg::*;
#(
    parameter int MEM_ADDR_BITS    = 10,
    parameter int MEM_DATA_BITS    = 512,
    parameter int LANE_BITS        = LANE_BITS_DEF,
    parameter int MEM_READ_LATENCY = 2
) (
    input  logic                     core_clk,
    input  logic                     core_reset,
    input  logic                     start,
    input  logic [MEM_ADDR_BITS:0]   size,
    output logic                     busy,
    output logic                     done,
    output logic [31:0]              cycles,
    output logic                     rd_en,
    output logic [MEM_ADDR_BITS-1:0] rd_addr,
    input  logic [MEM_DATA_BITS-1:0] rd_a_data,
    input  logic [MEM_DATA_BITS-1:0] rd_b_data,
    output logic                     wr_en,
    output logic [MEM_ADDR_BITS-1:0] wr_addr,
    output logic [MEM_DATA_BITS-1:0] wr_data
);

    localparam int NL = MEM_DATA_BITS / LANE_BITS;
    localparam logic [MEM_ADDR_BITS:0] SZ_ONE =
        {{MEM_ADDR_BITS{1'b0}}, 1'b1};
    localparam logic [MEM_ADDR_BITS:0] SZ_MAX =
        {1'b1, {MEM_ADDR_BITS{1'b0}}};

    state_t state_q, state_d;

    logic [MEM_ADDR_BITS:0]   size_q, size_d, size_c;
    logic [MEM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [31:0]              cnt_q, cnt_d;
    logic [31:0]              cycles_q, cycles_d;

    logic [MEM_READ_LATENCY-1:0] vld_q;
    logic [MEM_ADDR_BITS-1:0]    pa_q [MEM_READ_LATENCY];

    logic                     wr_en_q;
    logic [MEM_ADDR_BITS-1:0] wr_addr_q;
    logic [MEM_DATA_BITS-1:0] wr_data_q;
    logic [MEM_DATA_BITS-1:0] sum_w;

    logic accept, rd_last, drain_end;

    assign size_c    = (size > SZ_MAX) ? SZ_MAX : size;
    assign accept    = (state_q == ST_IDLE) && start;
    assign rd_last   = ({1'b0, addr_q} == (size_q - SZ_ONE));
    assign drain_end = wr_en_q && (vld_q == '0);

    always_ff @(posedge core_clk) begin
        if (core_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (size == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (rd_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_end) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q != ST_IDLE);
        done  = (state_q == ST_DONE);
        rd_en = (state_q == ST_READ);
    end

    always_comb begin
        size_d   = size_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
        if (accept) begin
            size_d = size_c;
            addr_d = '0;
            cnt_d  = 32'd1;
        end else if (state_q != ST_IDLE) begin
            cnt_d = cnt_q + 32'd1;
        end
        if (state_q == ST_READ) begin
            addr_d = addr_q + 1'b1;
        end
        if (state_q == ST_DONE) begin
            cycles_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge core_clk) begin
        if (core_reset) begin
            size_q   <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            cycles_q <= '0;
        end else begin
            size_q   <= size_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
        end
    end

    // Read-side valid/address pipe aligned with the SRAM latency.
    always_ff @(posedge core_clk) begin
        if (core_reset) begin
            vld_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            for (int i = 0; i < MEM_READ_LATENCY; i++) begin
                pa_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_en;
            pa_q[0]  <= rd_addr;
            for (int i = 1; i < MEM_READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                pa_q[i]  <= pa_q[i-1];
            end
            wr_en_q <= vld_q[MEM_READ_LATENCY-1];
            if (vld_q[MEM_READ_LATENCY-1]) begin
                wr_addr_q <= pa_q[MEM_READ_LATENCY-1];
                wr_data_q <= sum_w;
            end
        end
    end

    for (genvar g = 0; g < NL; g++) begin : g_lane
        sram_add_lane #(
            .LANE_BITS(LANE_BITS)
        ) u_lane (
            .a_i(rd_a_data[g*LANE_BITS +: LANE_BITS]),
            .b_i(rd_b_data[g*LANE_BITS +: LANE_BITS]),
            .s_o(sum_w[g*LANE_BITS +: LANE_BITS])
        );
    end

    assign rd_addr = addr_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign cycles  = cycles_q;

endmodule

// File: tb/tb_sram_add_sequencer.sv
// Scoreboard bench for sram_add_sequencer with a 2-cycle SRAM model.
// Define SRAM_ADD_SATURATE_EN for both RTL and bench to test saturation.
module tb_sram_add_sequencer;

    localparam int AW  = 10;
    localparam int DW  = 512;
    localparam int LB  = 8;
    localparam int LAT = 2;
    localparam int NL  = DW / LB;
`ifdef SRAM_ADD_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   size;
    logic          busy, done, rd_en, wr_en;
    logic [31:0]   cycles;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] rd_a_data, rd_b_data, wr_data;

    always #5 clk = ~clk;

    sram_add_sequencer #(
        .MEM_ADDR_BITS(AW),
        .MEM_DATA_BITS(DW),
        .LANE_BITS(LB),
        .MEM_READ_LATENCY(LAT)
    ) dut (
        .core_clk(clk),
        .core_reset(rst),
        .start(start),
        .size(size),
        .busy(busy),
        .done(done),
        .cycles(cycles),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_a_data(rd_a_data),
        .rd_b_data(rd_b_data),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data)
    );

    int checks = 0;
    int passes = 0;
    int mode   = 0;
    int rdcnt  = 0;
    logic [AW-1:0] last_wa = '0;
    logic [AW-1:0] d1 = '0, d2 = '0;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    wr_t q[$];

    function automatic logic [DW-1:0] gen_a(int md, logic [AW-1:0] ad);
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < NL; i++) begin
            if (md == 0)      w[i*LB +: LB] = 8'(i);
            else if (md == 1) w[i*LB +: LB] = (i == 0) ? 8'hF0 : 8'(ad) + 8'(i);
            else              w[i*LB +: LB] = 8'(ad) ^ 8'(i);
        end
        return w;
    endfunction

    function automatic logic [DW-1:0] gen_b(int md);
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < NL; i++) begin
            if (md == 0)      w[i*LB +: LB] = 8'h01;
            else if (md == 1) w[i*LB +: LB] = (i == 0) ? 8'h20 : 8'h03;
            else              w[i*LB +: LB] = 8'h80;
        end
        return w;
    endfunction

    function automatic logic [DW-1:0] exp_word(int md, logic [AW-1:0] ad);
        logic [DW-1:0] w;
        logic [7:0]    a;
        w = '0;
        for (int i = 0; i < NL; i++) begin
            if (md == 0) begin
                w[i*LB +: LB] = 8'(i + 1);
            end else if (md == 1) begin
                if (i == 0) w[i*LB +: LB] = SAT ? 8'hFF : 8'h10;
                else        w[i*LB +: LB] = 8'(ad) + 8'(i) + 8'h03;
            end else begin
                a = 8'(ad) ^ 8'(i);
                if (SAT && a >= 8'h80) w[i*LB +: LB] = 8'hFF;
                else                   w[i*LB +: LB] = a + 8'h80;
            end
        end
        return w;
    endfunction

    always @(posedge clk) begin
        d1 <= rd_addr;
        d2 <= d1;
    end

    always_comb begin
        rd_a_data = gen_a(mode, d2);
        rd_b_data = gen_b(mode);
    end

    always @(negedge clk) begin
        wr_t e;
        if (rd_en) rdcnt++;
        if (wr_en) begin
            last_wa = wr_addr;
            checks++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_wr addr=%0d", wr_addr);
            end else begin
                e = q.pop_front();
                if (wr_addr === e.a && wr_data === e.d) passes++;
                else $display("FAIL wr got a=%0d d=%h exp a=%0d d=%h",
                              wr_addr, wr_data, e.a, e.d);
            end
        end
    end

    task automatic check(string nm, longint act, longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    endtask

    task automatic run(int sz, int md, bit repulse);
        int n, k, exp_done, exp_cyc;
        n        = (sz > 1024) ? 1024 : sz;
        exp_done = (n == 0) ? 1 : n + LAT + 2;
        exp_cyc  = (n == 0) ? 2 : n + LAT + 3;
        mode     = md;
        for (int a = 0; a < n; a++) begin
            q.push_back('{a: AW'(a), d: exp_word(md, AW'(a))});
        end
        rdcnt = 0;
        @(negedge clk);
        start = 1'b1;
        size  = 11'(sz);
        @(negedge clk);
        start = 1'b0;
        k     = 1;
        check("busy_run", longint'(busy), 1);
        while (!done && k < 4000) begin
            @(negedge clk);
            k++;
            if (repulse && k == 2) begin
                start = 1'b1;
                size  = 11'd9;
            end else begin
                start = 1'b0;
            end
        end
        check("done_cycle", k, exp_done);
        @(negedge clk);
        check("busy_end", longint'(busy), 0);
        check("done_pulse", longint'(done), 0);
        check("cycles", longint'(cycles), exp_cyc);
        check("rd_count", rdcnt, n);
        check("pending_wr", q.size(), 0);
        if (n > 0) check("last_wr_addr", longint'(last_wa), n - 1);
        q.delete();
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        size  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_rd_en", longint'(rd_en), 0);
        check("rst_wr_en", longint'(wr_en), 0);
        check("rst_cycles", longint'(cycles), 0);
        check("rst_wr_data", longint'(wr_data[63:0]), 0);
        rst = 1'b0;
        @(negedge clk);

        run(4, 0, 1'b0);
        run(4, 1, 1'b0);
        run(0, 0, 1'b0);
        run(4, 0, 1'b1);

        mode  = 0;
        rdcnt = 0;
        @(negedge clk);
        start = 1'b1;
        size  = 11'd8;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_rd_en", longint'(rd_en), 0);
        check("midrst_wr_en", longint'(wr_en), 0);
        check("midrst_busy", longint'(busy), 0);
        check("midrst_cycles", longint'(cycles), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_rd_count", rdcnt, 3);

        run(4, 0, 1'b0);
        run(1024, 2, 1'b0);
        run(2047, 2, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sram_add_sequencer.md
SRAM_ADD_SEQUENCER -- requirements
Module: sram_add_sequencer

Interface
REQ-001 SHALL have parameter MEM_ADDR_BITS, default 10: word address width of the source and destination SRAMs.
REQ-002 SHALL have parameter MEM_DATA_BITS, default 512: SRAM word width, a multiple of LANE_BITS.
REQ-003 SHALL have parameter LANE_BITS, default 8: unsigned lane width.
REQ-004 SHALL have parameter MEM_READ_LATENCY, default 2: cycles from rd_en to valid read data.
REQ-005 SHALL have port core_clk, input, 1: the only clock.
REQ-006 SHALL have port core_reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: start request.
REQ-008 SHALL have port size, input, MEM_ADDR_BITS+1: word count, sampled at start acceptance.
REQ-009 SHALL have port busy, output, 1: operation in progress.
REQ-010 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port cycles, output, 32: length of the last run in cycles.
REQ-012 SHALL have port rd_en, output, 1: read strobe to SRAM A and SRAM B.
REQ-013 SHALL have port rd_addr, output, MEM_ADDR_BITS: read address.
REQ-014 SHALL have port rd_a_data, input, MEM_DATA_BITS: SRAM A read data.
REQ-015 SHALL have port rd_b_data, input, MEM_DATA_BITS: SRAM B read data.
REQ-016 SHALL have port wr_en, output, 1: write strobe to SRAM C.
REQ-017 SHALL have port wr_addr, output, MEM_ADDR_BITS: write address.
REQ-018 SHALL have port wr_data, output, MEM_DATA_BITS: write data.

Function
REQ-019 SHALL implement the states IDLE, READ, DRAIN and DONE.
REQ-020 SHALL accept start only in IDLE, latch size, and ignore start in every other state.
REQ-021 SHALL go IDLE->READ on an accepted start with size>0, and IDLE->DONE on an accepted start with size==0, issuing no reads or writes.
REQ-022 SHALL clamp a latched size above 2**MEM_ADDR_BITS to 2**MEM_ADDR_BITS.
REQ-023 SHALL assert rd_en once per cycle in READ, with rd_addr running 0..size-1, then go READ->DRAIN.
REQ-024 SHALL delay rd_en/rd_addr through a MEM_READ_LATENCY-deep valid/address pipe and register the sum one cycle after data arrives.
REQ-025 SHALL therefore drive wr_en exactly MEM_READ_LATENCY+1 cycles after the corresponding rd_en, with wr_addr equal to that rd_addr.
REQ-026 SHALL go DRAIN->DONE in the cycle after the last wr_en.
REQ-027 SHALL hold DONE for one cycle with done=1 and then return to IDLE.
REQ-028 SHALL add each LANE_BITS lane of A and B independently, with no carry between lanes.
REQ-029 SHALL hold busy=1 from the cycle after start acceptance through the DONE cycle inclusive.
REQ-030 SHALL count cycles from the acceptance cycle through the DONE cycle, both inclusive: size+MEM_READ_LATENCY+3 cycles, or 2 when size==0.
REQ-031 SHALL hold cycles until the next accepted start.

Reset
REQ-032 SHALL, on core_reset, set state to IDLE and clear busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data, cycles and the pipe valid bits.
REQ-033 SHALL, on reset mid-operation, drop wr_en and rd_en in the next cycle and never complete the in-flight writes.

Configuration
REQ-034 SHALL, with SRAM_ADD_SATURATE_EN defined, clamp each lane sum to 2**LANE_BITS-1.
REQ-035 SHALL, without SRAM_ADD_SATURATE_EN, wrap each lane sum modulo 2**LANE_BITS.

Structure
REQ-036 SHALL take the state enum type and the LANE_BITS default from the shared package sram_add_pkg.
REQ-037 SHALL build the lane logic from a generate loop of sub-module sram_add_lane, one adder per lane, containing the saturate option.

Verification
REQ-038 SHALL cover: size=4, MEM_READ_LATENCY=2, A lane i = i, B = 0x01 everywhere -> four writes to addr 0..3, lane i = i+1, done at cycle 8 after acceptance, cycles=9.
REQ-039 SHALL cover: lane A=0xF0, B=0x20 -> 0x10 without SRAM_ADD_SATURATE_EN, 0xFF with it, neighbouring lanes unaffected.
REQ-040 SHALL cover: size=0 -> no rd_en or wr_en, done one cycle after acceptance, cycles=2.
REQ-041 SHALL cover: start pulsed again during READ with size=9 -> ignored, the run completes with the original size and its write count unchanged.
REQ-042 SHALL cover: core_reset asserted 3 cycles into READ -> wr_en and rd_en 0 from the next cycle, busy=0, and a subsequent start runs normally.
REQ-043 SHALL cover: size=1024 and size=2047 -> both perform 1024 writes, last wr_addr=1023, cycles=1029.
